// File: rtl/pwm_glow_pkg.sv
// Shared types for the PWM glow bank: per-channel LED modes, ramp direction
// and the prescaler width helper.
package pwm_glow_pkg;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        GLOW     = 2'd1,
        GLOW_INV = 2'd2,
        ON       = 2'd3
    } mode_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

    // A divider of 1 still needs a one-bit counter that simply stays at zero.
    function automatic int pre_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/pwm_glow_ramp.sv
// Triangle ramp generator: a prescaler produces ramp ticks, and an UP/DOWN FSM
// walks the level 0..MAX..0. Prescaler, level and direction freeze while enable is low.
module pwm_glow_ramp
    import pwm_glow_pkg::*;
#(
    parameter int PWM_BITS = 4,
    parameter int STEP_DIV = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    output logic [PWM_BITS-1:0] level
);

    localparam int                  PRE_W    = pre_width(STEP_DIV);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] MAX      = '1;

    dir_e                dir;
    dir_e                dir_next;
    logic [PWM_BITS-1:0] level_next;
    logic [PRE_W-1:0]    pre;
    logic [PRE_W-1:0]    pre_next;
    logic                tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            dir   <= UP;
            level <= '0;
            pre   <= '0;
        end else begin
            dir   <= dir_next;
            level <= level_next;
            pre   <= pre_next;
        end
    end

    // Turnaround steps straight to the neighbouring level so the peak and the
    // floor each appear for only one tick per triangle.
    always_comb begin
        dir_next   = dir;
        level_next = level;
        pre_next   = pre;
        tick       = 1'b0;
        if (enable) begin
            if (pre == PRE_LAST) begin
                pre_next = '0;
                tick     = 1'b1;
            end else begin
                pre_next = pre + 1'b1;
            end
        end
        if (tick) begin
            case (dir)
                UP: begin
                    if (level == MAX) begin
                        dir_next   = DOWN;
                        level_next = MAX - 1'b1;
                    end else begin
                        level_next = level + 1'b1;
                    end
                end
                DOWN: begin
                    if (level == '0) begin
                        dir_next   = UP;
                        level_next = PWM_BITS'(1);
                    end else begin
                        level_next = level - 1'b1;
                    end
                end
                default: begin
                    dir_next = UP;
                end
            endcase
        end
    end

endmodule

// File: rtl/pwm_glow_bank.sv
// Bank of PWM LED channels sharing one triangle ramp. Optional macro
// PWM_GLOW_GAMMA_EN squares the duty curve: f(x) = (x*x) >> PWM_BITS.
module pwm_glow_bank
    import pwm_glow_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int PWM_BITS = 4,
    parameter int STEP_DIV = 2097152
) (
    input  logic                  clk_25mhz,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [2*CHANNELS-1:0] mode,
    output logic [CHANNELS-1:0]   led,
    output logic                  period_start,
    output logic [PWM_BITS-1:0]   level
);

    localparam logic [PWM_BITS-1:0] MAX = '1;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_q    [CHANNELS];
    logic [PWM_BITS-1:0] duty_next [CHANNELS];
    mode_e               mode_q    [CHANNELS];
    mode_e               mode_in   [CHANNELS];

    function automatic logic [PWM_BITS-1:0] shape(input logic [PWM_BITS-1:0] x);
`ifdef PWM_GLOW_GAMMA_EN
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, x} * {{PWM_BITS{1'b0}}, x};
        return sq[2*PWM_BITS-1:PWM_BITS];
`else
        return x;
`endif
    endfunction

    pwm_glow_ramp #(
        .PWM_BITS (PWM_BITS),
        .STEP_DIV (STEP_DIV)
    ) u_ramp (
        .clk    (clk_25mhz),
        .rst    (rst),
        .enable (enable),
        .level  (level)
    );

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            mode_in[i]   = mode_e'(mode[2*i +: 2]);
            duty_next[i] = '0;
            case (mode_in[i])
                GLOW:     duty_next[i] = shape(level);
                GLOW_INV: duty_next[i] = shape(MAX - level);
                ON:       duty_next[i] = MAX;
                default:  duty_next[i] = '0;
            endcase
        end
    end

    // Duty and mode only change on the last count of a period, so a period
    // never mixes two settings; a coincident ramp tick is seen next period.
    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            pwm_cnt      <= '0;
            period_start <= 1'b0;
            led          <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_q[i] <= '0;
                mode_q[i] <= OFF;
            end
        end else begin
            pwm_cnt      <= pwm_cnt + 1'b1;
            period_start <= (pwm_cnt == '0);
            for (int i = 0; i < CHANNELS; i++) begin
                led[i] <= (mode_q[i] == ON) || (pwm_cnt < duty_q[i]);
                if (pwm_cnt == MAX) begin
                    duty_q[i] <= duty_next[i];
                    mode_q[i] <= mode_in[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_glow_bank.sv
// Scoreboard bench for pwm_glow_bank: a STEP_DIV=2 bank and a STEP_DIV=1 bank
// share clock and inputs; expectations are queued at drive time and popped after the edge.
module tb_pwm_glow_bank;

    localparam int CH = 4;
    localparam int PB = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   led;
    logic [CH-1:0]   led1;
    logic            period_start;
    logic            ps1;
    logic [PB-1:0]   level;
    logic [PB-1:0]   level1;

    always #5 clk = ~clk;

    pwm_glow_bank #(.CHANNELS(CH), .PWM_BITS(PB), .STEP_DIV(2)) dut (
        .clk_25mhz    (clk),
        .rst          (rst),
        .enable       (enable),
        .mode         (mode),
        .led          (led),
        .period_start (period_start),
        .level        (level)
    );

    pwm_glow_bank #(.CHANNELS(CH), .PWM_BITS(PB), .STEP_DIV(1)) dut_fast (
        .clk_25mhz    (clk),
        .rst          (rst),
        .enable       (enable),
        .mode         (mode),
        .led          (led1),
        .period_start (ps1),
        .level        (level1)
    );

    typedef enum {S_LEVEL, S_PS, S_LEDS, S_LEVEL1, S_PS1, S_LEDS1, S_HIGH} sel_e;
    typedef struct {
        string tag;
        sel_e  sel;
        int    idx;
        int    exp;
    } item_t;

    item_t sb[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    high_cnt [CH];

    function automatic int tri_level(input int n);
        int m;
        m = n % 30;
        return (m <= 15) ? m : 30 - m;
    endfunction

    function automatic int shape(input int x);
`ifdef PWM_GLOW_GAMMA_EN
        return (x * x) >> PB;
`else
        return x;
`endif
    endfunction

    function automatic logic [31:0] observe(input sel_e s, input int idx);
        case (s)
            S_LEVEL:  return 32'(level);
            S_PS:     return 32'(period_start);
            S_LEDS:   return 32'(led);
            S_LEVEL1: return 32'(level1);
            S_PS1:    return 32'(ps1);
            S_LEDS1:  return 32'(led1);
            default:  return 32'(high_cnt[idx]);
        endcase
    endfunction

    task automatic expect_sig(input string tag, input sel_e s, input int idx, input int e);
        item_t it;
        it.tag = tag;
        it.sel = s;
        it.idx = idx;
        it.exp = e;
        sb.push_back(it);
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [2*CH-1:0] m);
        rst    = r;
        enable = e;
        mode   = m;
    endtask

    task automatic checkOutput();
        item_t       it;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            it  = sb.pop_front();
            obs = observe(it.sel, it.idx);
            vectors++;
            assert (obs === 32'(it.exp)) else begin
                miscompares++;
                $error("[TB] FAIL %s[%0d] observed=%0d expected=%0d", it.tag, it.idx, obs, it.exp);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic sync_period();
        int n;
        n = 0;
        @(negedge clk);
        while (period_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        assert (period_start === 1'b1) else begin
            miscompares++;
            $error("[TB] FAIL sync_period observed=%b expected=1 within 40 cycles", period_start);
        end
    endtask

    // Counts led highs over one full period; mode may be changed at sample mid_cycle.
    task automatic count_period(input int mid_cycle, input logic [2*CH-1:0] mid_mode);
        sync_period();
        for (int i = 0; i < CH; i++) high_cnt[i] = 0;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            for (int i = 0; i < CH; i++) high_cnt[i] += (led[i] === 1'b1) ? 1 : 0;
            if (c == mid_cycle) applyStimulus(1'b0, enable, mid_mode);
        end
    endtask

    task automatic ramp_to(input int t, input logic [2*CH-1:0] m);
        applyStimulus(1'b1, 1'b0, m);
        step();
        step();
        applyStimulus(1'b0, 1'b1, m);
        repeat (2 * t) step();
        applyStimulus(1'b0, 1'b0, m);
        expect_sig("ramp_to_level", S_LEVEL, 0, t);
        step();
    endtask

    task automatic duty_case(input int t);
        ramp_to(t, 8'hE5);
        expect_sig("glow_ch0", S_HIGH, 0, shape(t));
        expect_sig("glow_ch1", S_HIGH, 1, shape(t));
        expect_sig("inv_ch2",  S_HIGH, 2, shape(15 - t));
        expect_sig("on_ch3",   S_HIGH, 3, 16);
        count_period(-1, 8'hE5);
        checkOutput();
    endtask

    initial begin
        applyStimulus(1'b1, 1'b1, 8'h55);
        step();
        step();
        applyStimulus(1'b0, 1'b1, 8'h55);
        repeat (37) step();

        $display("[TB] reset held mid-ramp");
        applyStimulus(1'b1, 1'b1, 8'h55);
        for (int r = 0; r < 3; r++) begin
            expect_sig("rst_level", S_LEVEL, r, 0);
            expect_sig("rst_ps",    S_PS,    r, 0);
            expect_sig("rst_led",   S_LEDS,  r, 0);
            expect_sig("rst_level1", S_LEVEL1, r, 0);
            expect_sig("rst_led1",  S_LEDS1, r, 0);
            step();
        end

        $display("[TB] ramp and period_start after reset");
        applyStimulus(1'b0, 1'b1, 8'h55);
        for (int k = 1; k <= 64; k++) begin
            expect_sig("ramp_level",  S_LEVEL,  k, tri_level(k / 2));
            expect_sig("period_start", S_PS,    k, ((k - 1) % 16 == 0) ? 1 : 0);
            expect_sig("fast_level",  S_LEVEL1, k, tri_level(k));
            expect_sig("fast_ps",     S_PS1,    k, ((k - 1) % 16 == 0) ? 1 : 0);
            step();
        end

        $display("[TB] enable low freezes ramp");
        applyStimulus(1'b0, 1'b0, 8'h55);
        for (int k = 0; k < 10; k++) begin
            expect_sig("freeze_level",  S_LEVEL,  k, 2);
            expect_sig("freeze_level1", S_LEVEL1, k, 4);
            step();
        end
        applyStimulus(1'b0, 1'b1, 8'h55);
        expect_sig("resume_level",  S_LEVEL,  0, 2);
        expect_sig("resume_level1", S_LEVEL1, 0, 5);
        step();
        expect_sig("resume_level",  S_LEVEL,  1, 3);
        expect_sig("resume_level1", S_LEVEL1, 1, 6);
        step();

        $display("[TB] duty per latched level");
        duty_case(5);
        duty_case(0);
        duty_case(15);
        duty_case(8);

        $display("[TB] mid-period mode change");
        duty_case(5);
        expect_sig("mid_old_ch0", S_HIGH, 0, shape(5));
        expect_sig("mid_old_ch1", S_HIGH, 1, shape(5));
        expect_sig("mid_old_ch2", S_HIGH, 2, shape(10));
        expect_sig("mid_old_ch3", S_HIGH, 3, 16);
        count_period(8, 8'h27);
        checkOutput();
        expect_sig("mid_new_ch0", S_HIGH, 0, 16);
        expect_sig("mid_new_ch1", S_HIGH, 1, shape(5));
        expect_sig("mid_new_ch2", S_HIGH, 2, shape(10));
        expect_sig("mid_new_ch3", S_HIGH, 3, 0);
        count_period(-1, 8'h27);
        checkOutput();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_glow_bank.md
PWM_GLOW_BANK -- requirements
Module: pwm_glow_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, number of independent LED outputs.
REQ-002 SHALL have parameter PWM_BITS, default 4, duty/level width; MAX = 2**PWM_BITS-1.
REQ-003 SHALL have parameter STEP_DIV, default 2097152, clocks per ramp step (>=1).
REQ-004 SHALL have port clk_25mhz  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port enable  input  1  high = ramp advances; low = ramp frozen, PWM keeps running.
REQ-007 SHALL have port mode  input  2*CHANNELS  per-channel mode, channel i at bits [2i+1:2i].
REQ-008 SHALL have port led  output  CHANNELS  registered PWM output per channel.
REQ-009 SHALL have port period_start  output  1  one-cycle pulse on the first cycle of each PWM period.
REQ-010 SHALL have port level  output  PWM_BITS  current ramp level, for debug.

Function
REQ-011 SHALL run pwm_cnt (PWM_BITS) incrementing every clock, wrapping MAX->0.
REQ-012 SHALL run a prescaler 0..STEP_DIV-1; ramp tick when prescaler==STEP_DIV-1 and enable=1; prescaler holds while enable=0.
REQ-013 SHALL implement ramp FSM states UP/DOWN: UP tick: level<MAX -> level+1, level==MAX -> DOWN and level=MAX-1; DOWN tick: level>0 -> level-1, level==0 -> UP and level=1; triangle period 2*MAX ticks.
REQ-014 SHALL decode modes: 0 OFF (duty 0), 1 GLOW (duty=f(level)), 2 GLOW_INV (duty=f(MAX-level)), 3 ON (led forced 1).
REQ-015 SHALL latch per-channel duty_q and mode_q only when pwm_cnt==MAX, so new values take effect at pwm_cnt==0; no mid-period change.
REQ-016 SHALL drive led[i] <= (mode_q==ON) | (pwm_cnt < duty_q[i]); one clock latency from pwm_cnt.
REQ-017 SHALL thus give duty 0 = constant low, duty MAX = high for MAX of 2**PWM_BITS cycles.
REQ-018 SHALL pulse period_start for exactly one clock, registered, one cycle after pwm_cnt==0.
REQ-019 SHALL, when ramp tick and latch coincide, latch the pre-tick level; new level applies next period.
REQ-020 SHALL, with enable=0, hold level, direction and prescaler; mode changes still latch at period boundary.

Reset
REQ-021 SHALL on rst=1 at a clock edge clear pwm_cnt, prescaler, level, duty_q, mode_q (OFF), led, period_start, and set direction UP.
REQ-022 SHALL, on rst mid-ramp or mid-period, restart from the reset state; first period_start pulse appears 1 cycle after rst deasserts.

Configuration
REQ-023 SHALL honour macro PWM_GLOW_GAMMA_EN: defined -> f(x) = (x*x) >> PWM_BITS (full-width product, then truncate); undefined -> f(x) = x.
REQ-024 SHALL keep f(0)=0 in both builds; with gamma and PWM_BITS=4, f(15)=14, f(8)=4.

Structure
REQ-025 SHALL place mode enum (OFF/GLOW/GLOW_INV/ON) and ramp direction enum (UP/DOWN) in shared package pwm_glow_pkg.
REQ-026 SHALL implement ramp FSM plus prescaler as sub-module pwm_glow_ramp, single instance shared by all channels.

Verification (CHANNELS=4, PWM_BITS=4, STEP_DIV=2 unless stated)
REQ-027 SHALL cover reset: rst held 3 cycles mid-ramp -> led=0, level=0, period_start=0; period_start first pulses 1 cycle after rst falls, then every 16 cycles.
REQ-028 SHALL cover ramp: enable=1 -> level sequence 0,1..15,14..0,1, one step per 2 clocks; enable=0 for 10 cycles freezes level.
REQ-029 SHALL cover duty: mode all GLOW, level latched 5 (no gamma) -> each led high exactly 5 of 16 cycles per period; GLOW_INV channel high 10 of 16.
REQ-030 SHALL cover modes: mode=OFF -> led 0 all period; ON -> led 1 all period; mode change mid-period -> applied only from the next period_start.
REQ-031 SHALL cover gamma build: PWM_GLOW_GAMMA_EN defined, latched level 15 -> high 14 of 16 cycles; level 8 -> high 4 of 16.
REQ-032 SHALL cover STEP_DIV=1: level steps every enabled clock and wraps UP->DOWN at 15 without skipping or repeating.
